// File: rtl/if_id_pkg.sv
// Shared constants and entry type for the IF/ID instruction queue.
`default_nettype none

package if_id_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          DEPTH     = 2;
  localparam int          PC_W      = 16;
  localparam int          INSTR_W   = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_entry_t;
endpackage

`default_nettype wire

// File: rtl/if_id_queue.sv
// 2-entry IF/ID FIFO between fetch and decode with flush and PC+4 output.
// Optional macro IF_ID_BYPASS_EN: zero-latency pass-through when the queue is empty.
`default_nettype none

module if_id_queue #(
  parameter int DATA_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_pc,
  output logic [DATA_WIDTH-1:0]  out_pc_plus4,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [1:0]             count
);
  import if_id_pkg::*;

  localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP_INSTR);

  logic [1:0]             r_count;
  logic                   r_wptr;
  logic                   r_rptr;
  logic [DATA_WIDTH-1:0]  r_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [DATA_WIDTH-1:0]  r_hold_pc;

  logic w_head_valid;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_head_valid = (r_count != 2'd0);
  assign in_ready     = (r_count != 2'd2);
  assign count        = r_count;

`ifdef IF_ID_BYPASS_EN
  assign w_bypass = (r_count == 2'd0) && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid = w_head_valid | w_bypass;
  // A bypassed entry consumed in the same cycle never enters storage.
  assign w_push    = in_valid && in_ready && !flush && !(w_bypass && out_ready);
  assign w_pop     = w_head_valid && out_ready && !flush;

  always_comb begin
    out_pc    = r_hold_pc;
    out_instr = NOP_W;
    if (w_bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (w_head_valid) begin
      out_pc    = r_pc[r_rptr];
      out_instr = r_instr[r_rptr];
    end
  end

  assign out_pc_plus4 = out_pc + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= 2'd0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_hold_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= NOP_W;
      end
    end else begin
      // Remember the presented head so out_pc stays stable once the queue empties.
      if (out_valid) r_hold_pc <= out_pc;
      if (flush) begin
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_pc[r_wptr]    <= in_pc;
          r_instr[r_wptr] <= in_instr;
          r_wptr          <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

`default_nettype wire
